// File: rtl/snn_lif_classifier.sv
// rtl/snn_lif_classifier.sv - adaptive-threshold LIF spiking classifier layer with argmax readout
//
// Purpose: N_IN binary input spikes drive N_OUT leaky integrate-and-fire neurons through a
// writable unsigned weight array. Each timestep accumulates one input row per cycle, then
// updates membranes and adaptive thresholds in a single FIRE cycle. After NUM_STEPS
// timesteps the per-output spike counters are scanned and the most active index reported.
//
// Ports:
//   clk_i, rst_i            clock and synchronous active-high reset
//   wr_en_i/addr/data       weight write (addr = i*N_OUT + j), accepted only while idle
//   in_valid_i/in_ready_o   timestep handshake, in_spikes_i captured on acceptance
//   spike_o                 one-cycle output spike vector after each FIRE
//   done_o                  one-cycle pulse when an inference completes
//   winner_o/count_o        argmax index and its spike count
module snn_lif_classifier #(
    parameter int N_IN          = 8,
    parameter int N_OUT         = 10,
    parameter int WIDTH_P       = 8,
    parameter int CNT_W         = 8,
    parameter int NUM_STEPS     = 16,
    parameter int THRESHOLD     = 32,
    parameter int THRESHOLD_INC = 4,
    parameter int THRESHOLD_DEC = 2,
    parameter int THRESHOLD_MIN = 16,
    parameter int LEAK_SHIFT    = 1,
    localparam int ADDR_W       = $clog2(N_IN * N_OUT),
    localparam int OUT_W        = $clog2(N_OUT)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [WIDTH_P-1:0] wr_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [N_IN-1:0]    in_spikes_i,
    output logic [N_OUT-1:0]   spike_o,
    output logic               done_o,
    output logic [OUT_W-1:0]   winner_o,
    output logic [CNT_W-1:0]   winner_count_o
);
    localparam int AW     = WIDTH_P + $clog2(N_IN);
    localparam int VW     = AW + 1;
    localparam int NW     = N_IN * N_OUT;
    localparam int STEP_W = $clog2(NUM_STEPS);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((N_IN - 1) * N_OUT);

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FIRE, S_ARGMAX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [WIDTH_P-1:0]  w_q   [NW];
    logic [VW-1:0]       acc_q [N_OUT];
    logic [VW-1:0]       mem_q [N_OUT];
    logic [VW-1:0]       thr_q [N_OUT];
    logic [CNT_W-1:0]    cnt_q [N_OUT];
    logic [N_IN-1:0]     spk_q;
    logic [ADDR_W-1:0]   base_q;
    logic [STEP_W-1:0]   step_q;
    logic [OUT_W-1:0]    oc_q;
    logic [N_OUT-1:0]    spike_q;
    logic [OUT_W-1:0]    win_q;
    logic [CNT_W-1:0]    win_cnt_q;

    logic [VW-1:0]       acc_add [N_OUT];
    logic [VW-1:0]       v_fire  [N_OUT];
    logic [VW-1:0]       thr_inc [N_OUT];
    logic [VW-1:0]       thr_dec [N_OUT];
    logic [CNT_W-1:0]    cnt_inc [N_OUT];
    logic [N_OUT-1:0]    fire_vec;
    logic                last_step;

    function automatic logic [VW-1:0] sat_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[VW] ? {VW{1'b1}} : s[VW-1:0];
    endfunction

    assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));

    // Per-neuron datapath. spk_q is shifted right each ACCUM cycle so bit 0 is always the
    // spike of the row addressed by base_q.
    always_comb begin
        fire_vec = '0;
        for (int j = 0; j < N_OUT; j++) begin
            acc_add[j]  = sat_add(acc_q[j], VW'(w_q[base_q + ADDR_W'(j)]));
            v_fire[j]   = sat_add(mem_q[j] - (mem_q[j] >> LEAK_SHIFT), acc_q[j]);
            fire_vec[j] = (v_fire[j] >= thr_q[j]);
            thr_inc[j]  = sat_add(thr_q[j], VW'(THRESHOLD_INC));
            thr_dec[j]  = (thr_q[j] >= VW'(THRESHOLD_MIN + THRESHOLD_DEC))
                        ? thr_q[j] - VW'(THRESHOLD_DEC) : VW'(THRESHOLD_MIN);
            cnt_inc[j]  = (cnt_q[j] == {CNT_W{1'b1}}) ? cnt_q[j] : cnt_q[j] + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid_i) state_d = S_ACCUM;
            S_ACCUM:  if (base_q == LAST_BASE) state_d = S_FIRE;
            S_FIRE:   state_d = last_step ? S_ARGMAX : S_IDLE;
            S_ARGMAX: if (oc_q == OUT_W'(N_OUT - 1)) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            spk_q     <= '0;
            base_q    <= '0;
            step_q    <= '0;
            oc_q      <= '0;
            spike_q   <= '0;
            win_q     <= '0;
            win_cnt_q <= '0;
            for (int k = 0; k < NW; k++) w_q[k] <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= '0;
                mem_q[j] <= '0;
                thr_q[j] <= VW'(THRESHOLD);
                cnt_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            spike_q <= '0;
            if (wr_en_i && state_q == S_IDLE && {1'b0, wr_addr_i} < (ADDR_W + 1)'(NW))
                w_q[wr_addr_i] <= wr_data_i;
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        spk_q  <= in_spikes_i;
                        base_q <= '0;
                        // First step of an inference starts a fresh count and readout.
                        if (step_q == '0) begin
                            win_q     <= '0;
                            win_cnt_q <= '0;
                            for (int j = 0; j < N_OUT; j++) cnt_q[j] <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    for (int j = 0; j < N_OUT; j++)
                        if (spk_q[0]) acc_q[j] <= acc_add[j];
                    spk_q  <= spk_q >> 1;
                    base_q <= base_q + ADDR_W'(N_OUT);
                end
                S_FIRE: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        acc_q[j] <= '0;
                        if (fire_vec[j]) begin
                            mem_q[j] <= '0;
                            thr_q[j] <= thr_inc[j];
                            cnt_q[j] <= cnt_inc[j];
                        end else begin
                            mem_q[j] <= v_fire[j];
                            thr_q[j] <= thr_dec[j];
                        end
                    end
                    spike_q <= fire_vec;
                    oc_q    <= '0;
                    step_q  <= last_step ? '0 : step_q + 1'b1;
                end
                S_ARGMAX: begin
                    // Strict compare keeps the lowest index on ties.
                    if (cnt_q[oc_q] > win_cnt_q) begin
                        win_q     <= oc_q;
                        win_cnt_q <= cnt_q[oc_q];
                    end
                    oc_q <= oc_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o     = (state_q == S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign spike_o        = spike_q;
    assign winner_o       = win_q;
    assign winner_count_o = win_cnt_q;
endmodule

// File: tb/tb_snn_lif_classifier.sv
// tb/tb_snn_lif_classifier.sv - self-checking bench for snn_lif_classifier
module tb_snn_lif_classifier;
    localparam int N_IN  = 8;
    localparam int N_OUT = 10;
    localparam int NSTEP = 16;

    logic       clk = 1'b0;
    logic       rst, wr_en, in_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data, in_spikes;
    logic       ready_a, ready_b, done_a, done_b;
    logic [9:0] spike_a, spike_b;
    logic [3:0] win_a, win_b;
    logic [7:0] wc_a;
    logic [1:0] wc_b;

    always #5 clk = ~clk;

    snn_lif_classifier dut_a (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .in_valid_i(in_valid), .in_ready_o(ready_a), .in_spikes_i(in_spikes),
        .spike_o(spike_a), .done_o(done_a), .winner_o(win_a), .winner_count_o(wc_a)
    );

    snn_lif_classifier #(.CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .in_valid_i(in_valid), .in_ready_o(ready_b), .in_spikes_i(in_spikes),
        .spike_o(spike_b), .done_o(done_b), .winner_o(win_b), .winner_count_o(wc_b)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    typedef struct {
        logic [7:0] spikes;
        logic [9:0] exp_spk;
    } vec_t;
    vec_t t1[5];

    int mw[80];
    int mv[10];
    int mthr[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 80; k++) mw[k] = 0;
        for (int j = 0; j < N_OUT; j++) begin
            mv[j] = 0;
            mthr[j] = 32;
        end
    endfunction

    function automatic logic [9:0] model_step(input logic [7:0] s);
        logic [9:0] r;
        int acc, vn;
        r = '0;
        for (int j = 0; j < N_OUT; j++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++) if (s[i]) acc += mw[i * N_OUT + j];
            if (acc > 4095) acc = 4095;
            vn = mv[j] - (mv[j] >> 1) + acc;
            if (vn > 4095) vn = 4095;
            if (vn >= mthr[j]) begin
                r[j] = 1'b1;
                mv[j] = 0;
                mthr[j] = (mthr[j] + 4 > 4095) ? 4095 : mthr[j] + 4;
            end else begin
                mv[j] = vn;
                mthr[j] = (mthr[j] - 2 < 16) ? 16 : mthr[j] - 2;
            end
        end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        check("rst_ready", ready_a, 1);
        check("rst_spike", spike_a, 0);
        check("rst_done", done_a, 0);
        check("rst_winner", win_a, 0);
        check("rst_wcount", wc_a, 0);
    endtask

    task automatic write_w(input int addr, input int data, input bit legal);
        wr_en = 1'b1; wr_addr = 7'(addr); wr_data = 8'(data);
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (legal) mw[addr] = data;
    endtask

    task automatic run_step(input logic [7:0] s, input logic [9:0] exp, input bit mid_wr);
        logic [9:0] e;
        int n;
        n = 0;
        while (!ready_a && n < 100) begin @(posedge clk); #1; n++; end
        check("step_ready", ready_a, 1);
        in_valid = 1'b1; in_spikes = s;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < N_IN + 1; k++) begin
            wr_en = mid_wr && (k == 2); wr_addr = 7'd0; wr_data = 8'd40;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        e = exp_q.pop_front();
        check("spike_a", spike_a, e);
        check("spike_b", spike_b, e);
    endtask

    task automatic check_done(input int wa, input int ca, input int wb, input int cb, input bit argmax_wr);
        int n;
        n = 0;
        check("argmax_busy", ready_a, 0);
        wr_en = argmax_wr; wr_addr = 7'd0; wr_data = 8'd40;
        while (!done_a && n < 50) begin @(posedge clk); #1; wr_en = 1'b0; n++; end
        wr_en = 1'b0;
        check("done_latency", n, N_OUT);
        check("done_b", done_b, 1);
        check("winner_a", win_a, wa);
        check("wcount_a", wc_a, ca);
        check("winner_b", win_b, wb);
        check("wcount_b", wc_b, cb);
        @(posedge clk); #1;
        check("done_pulse", done_a, 0);
        check("ready_after_done", ready_a, 1);
        check("winner_hold", win_a, wa);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; in_valid = 1'b0; in_spikes = '0;
        t1[0] = '{8'h01, 10'h001};
        t1[1] = '{8'h01, 10'h001};
        t1[2] = '{8'h01, 10'h001};
        t1[3] = '{8'h01, 10'h000};
        t1[4] = '{8'h01, 10'h001};
        repeat (2) @(posedge clk);
        #1;

        // Test 1: single weight, adaptive threshold pattern 1,1,1,0,1
        do_reset();
        write_w(0, 40, 1);
        for (int i = 0; i < 5; i++) begin
            run_step(t1[i].spikes, t1[i].exp_spk, 1'b0);
            if (i == 0) begin
                @(posedge clk); #1;
                check("spike_one_cycle", spike_a, 0);
            end
        end

        // Test 2: zero weights, dense input, no spikes, winner 0
        do_reset();
        for (int i = 0; i < NSTEP; i++) run_step(8'hFF, model_step(8'hFF), 1'b0);
        check_done(0, 0, 0, 0, 1'b0);

        // Test 3: tie between outputs 3 and 7 resolves to 3
        do_reset();
        for (int i = 0; i < N_IN; i++) begin
            write_w(i * N_OUT + 3, 40, 1);
            write_w(i * N_OUT + 7, 40, 1);
        end
        for (int i = 0; i < NSTEP; i++) run_step(8'h01, model_step(8'h01), 1'b0);
        check_done(3, 9, 3, 3, 1'b0);

        // Test 4: counter saturation on the CNT_W=2 instance
        do_reset();
        write_w(5, 200, 1);
        for (int i = 0; i < NSTEP; i++) run_step(8'h01, model_step(8'h01), 1'b0);
        check_done(5, 16, 5, 3, 1'b0);

        // Test 5: reset in the third ACCUM cycle discards the step and the weights
        do_reset();
        write_w(0, 40, 1);
        in_valid = 1'b1; in_spikes = 8'h01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("midrst_ready", ready_a, 1);
        check("midrst_spike", spike_a, 0);
        for (int i = 0; i < NSTEP; i++) run_step(8'h01, model_step(8'h01), 1'b0);
        check_done(0, 0, 0, 0, 1'b0);

        // Test 6: writes while busy are ignored, the same write while idle takes effect
        do_reset();
        run_step(8'h00, model_step(8'h00), 1'b1);
        for (int i = 1; i < NSTEP; i++) run_step(8'h00, model_step(8'h00), 1'b0);
        check_done(0, 0, 0, 0, 1'b1);
        run_step(8'h01, model_step(8'h01), 1'b0);
        check("busy_write_ignored", spike_a[0], 0);
        write_w(0, 40, 1);
        run_step(8'h01, model_step(8'h01), 1'b0);
        check("idle_write_used", spike_a[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
